// File: rtl/cache_way_data_array.sv
// cache_way_data_array: multi-way line store with power-up/clr clearing FSM and one-cycle registered reads.
module cache_way_data_array #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX = 4,
    parameter int NUM_WAYS = 4,
    parameter int WRITE_FIRST = 1,
    localparam int S_MASK = 2 ** S_OFFSET,
    localparam int S_LINE = 8 * S_MASK,
    localparam int NUM_SETS = 2 ** S_INDEX,
    localparam int S_WAY = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [S_INDEX-1:0] req_index,
    input  logic [S_WAY-1:0]  req_way,
    input  logic [S_MASK-1:0] req_wmask,
    input  logic [S_LINE-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [S_LINE-1:0] rsp_data,
    output logic              init_done
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0] state;
    logic [S_INDEX-1:0] cnt;
    logic [S_LINE-1:0] mem [NUM_WAYS][NUM_SETS];
    logic acc;
    logic rsp_q;
    logic [S_WAY-1:0] way;
    logic [S_LINE-1:0] old_line;
    logic [S_LINE-1:0] new_line;

    assign init_done = state == READY;
    assign req_ready = init_done && !clr;
    assign acc = req_valid && req_ready && !rst;
    assign way = (NUM_WAYS == 1) ? '0 : req_way;
    assign old_line = mem[way][req_index];
    // a response whose cycle coincides with reset is suppressed
    assign rsp_valid = rsp_q && !rst;

    always_comb begin
        new_line = old_line;
        for (int i = 0; i < S_MASK; i++)
            new_line[8*i +: 8] = req_wmask[i] ? req_wdata[8*i +: 8] : old_line[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state <= INIT;
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            state <= (cnt == S_INDEX'(NUM_SETS - 1)) ? READY : INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == INIT) begin
            for (int w = 0; w < NUM_WAYS; w++)
                mem[w][cnt] <= '0;
        end else if (acc) begin
            mem[way][req_index] <= new_line;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_q <= acc;
            if (acc)
                rsp_data <= (WRITE_FIRST != 0) ? new_line : old_line;
        end
    end
endmodule

// File: tb/tb_cache_way_data_array.sv
// tb_cache_way_data_array: randomized self-checking bench, both read-during-write modes side by side.
module tb_cache_way_data_array;
    typedef logic [255:0] line_t;
    localparam int NSETS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic req_valid = 1'b0;
    logic [3:0] req_index = '0;
    logic [1:0] req_way = '0;
    logic [31:0] req_wmask = '0;
    line_t req_wdata = '0;
    logic ready1, ready0, rsp_valid1, rsp_valid0, init_done1, init_done0;
    line_t rsp_data1, rsp_data0;

    int checks = 0;
    int errors = 0;

    line_t m [4][16];
    int busy = NSETS;
    logic exp_valid = 1'b0;
    line_t exp_d1 = '0;
    line_t exp_d0 = '0;
    line_t a5 = {32{8'hA5}};

    always #5 clk = ~clk;

    cache_way_data_array #(.WRITE_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(ready1),
        .req_index(req_index), .req_way(req_way), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .init_done(init_done1)
    );

    cache_way_data_array #(.WRITE_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(ready0),
        .req_index(req_index), .req_way(req_way), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .init_done(init_done0)
    );

    function automatic line_t rnd_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
        return l;
    endfunction

    task automatic clear_model();
        for (int w = 0; w < 4; w++)
            for (int s = 0; s < 16; s++) m[w][s] = '0;
    endtask

    // model: a clear (rst or clr) zeroes everything and blocks requests for NSETS cycles
    task automatic step();
        line_t old, nw;
        logic acc;
        acc = req_valid && busy == 0 && !clr && !rst;
        if (rst) begin
            busy = NSETS;
            exp_valid = 1'b0;
            exp_d1 = '0;
            exp_d0 = '0;
            clear_model();
        end else begin
            if (acc) begin
                old = m[req_way][req_index];
                nw = old;
                for (int i = 0; i < 32; i++) if (req_wmask[i]) nw[8*i +: 8] = req_wdata[8*i +: 8];
                m[req_way][req_index] = nw;
                exp_d1 = nw;
                exp_d0 = old;
            end
            exp_valid = acc;
            if (clr) begin
                busy = NSETS;
                clear_model();
            end else if (busy > 0) busy--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int s, input int w, input logic [31:0] mask, input line_t d);
        req_valid = 1'b1;
        req_index = 4'(s);
        req_way = 2'(w);
        req_wmask = mask;
        req_wdata = d;
        step();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_index = 4'($urandom());
        req_way = 2'($urandom());
        req_wmask = $urandom();
        req_wdata = rnd_line();
        step();
    endtask

    task automatic count_init(input string name);
        for (int i = 0; i < NSETS; i++) begin
            checks++;
            if (ready1 !== 1'b0 || ready0 !== 1'b0) begin
                errors++;
                $display("FAIL %s ready cycle %0d: got %b/%b want 0", name, i, ready1, ready0);
            end
            idle();
        end
        checks++;
        if (ready1 !== 1'b1 || init_done1 !== 1'b1 || ready0 !== 1'b1) begin
            errors++;
            $display("FAIL %s ready after init: got %b/%b/%b want 1", name, ready1, init_done1, ready0);
        end
    endtask

    task automatic read_all_zero(input string name);
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                issue(s, w, 32'h0, rnd_line());
                checks++;
                if (rsp_valid1 !== 1'b1 || rsp_data1 !== '0 || rsp_data0 !== '0) begin
                    errors++;
                    $display("FAIL %s set %0d way %0d: valid=%b d1=%h d0=%h want 1 and zero", name, s, w, rsp_valid1, rsp_data1, rsp_data0);
                end
            end
        idle();
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL %s idle rsp_valid: got %b/%b want 0", name, rsp_valid1, rsp_valid0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        checks++;
        if (ready1 !== 1'b0 || init_done1 !== 1'b0 || rsp_valid1 !== 1'b0 || rsp_data1 !== '0 || rsp_data0 !== '0) begin
            errors++;
            $display("FAIL reset state: ready=%b done=%b valid=%b d1=%h want 0", ready1, init_done1, rsp_valid1, rsp_data1);
        end
        rst = 1'b0;
        count_init("reset");
        read_all_zero("reset_read");
    endtask

    task automatic test_write_read();
        issue(3, 2, 32'hFFFF_FFFF, a5);
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_data1 !== a5 || rsp_data0 !== '0) begin
            errors++;
            $display("FAIL write_full: valid=%b d1=%h d0=%h want 1 a5 0", rsp_valid1, rsp_data1, rsp_data0);
        end
        issue(3, 2, 32'h0, rnd_line());
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_data1 !== a5 || rsp_data0 !== a5) begin
            errors++;
            $display("FAIL read_full: valid=%b d1=%h d0=%h want a5", rsp_valid1, rsp_data1, rsp_data0);
        end
        idle();
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_data1 !== a5 || rsp_data0 !== a5) begin
            errors++;
            $display("FAIL hold: valid=%b d1=%h d0=%h want 0 and held a5", rsp_valid1, rsp_data1, rsp_data0);
        end
    endtask

    task automatic test_partial();
        line_t d, want;
        d = rnd_line();
        d[7:0] = 8'h3C;
        want = {{31{8'hA5}}, 8'h3C};
        issue(3, 2, 32'h1, d);
        checks++;
        if (rsp_data1 !== want || rsp_data0 !== a5) begin
            errors++;
            $display("FAIL partial_write: d1=%h d0=%h want %h / %h", rsp_data1, rsp_data0, want, a5);
        end
        issue(3, 2, 32'h0, rnd_line());
        checks++;
        if (rsp_data1 !== want || rsp_data0 !== want) begin
            errors++;
            $display("FAIL partial_read: d1=%h d0=%h want %h", rsp_data1, rsp_data0, want);
        end
    endtask

    task automatic test_ways();
        line_t x1, x0;
        x1 = rnd_line();
        x0 = ~x1;
        issue(5, 1, 32'hFFFF_FFFF, x1);
        issue(5, 0, 32'hFFFF_FFFF, x0);
        issue(5, 1, 32'h0, rnd_line());
        checks++;
        if (rsp_data1 !== x1 || rsp_data0 !== x1) begin
            errors++;
            $display("FAIL way1: d1=%h d0=%h want %h", rsp_data1, rsp_data0, x1);
        end
        issue(5, 0, 32'h0, rnd_line());
        checks++;
        if (rsp_data1 !== x0 || rsp_data0 !== x0) begin
            errors++;
            $display("FAIL way0: d1=%h d0=%h want %h", rsp_data1, rsp_data0, x0);
        end
        for (int w = 0; w < 4; w++) begin
            issue(6, w, 32'h0, rnd_line());
            checks++;
            if (rsp_data1 !== '0 || rsp_data0 !== '0) begin
                errors++;
                $display("FAIL set6 way %0d: d1=%h d0=%h want 0", w, rsp_data1, rsp_data0);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 400; n++) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_index = 4'($urandom_range(0, 3));
            req_way = 2'($urandom());
            case ($urandom_range(0, 2))
                0: req_wmask = 32'h0;
                1: req_wmask = 32'hFFFF_FFFF;
                default: req_wmask = $urandom();
            endcase
            req_wdata = rnd_line();
            step();
            checks++;
            if (rsp_valid1 !== exp_valid || rsp_valid0 !== exp_valid || rsp_data1 !== exp_d1 || rsp_data0 !== exp_d0 || ready1 !== (busy == 0)) begin
                errors++;
                $display("FAIL random %0d: valid=%b/%b want %b d1=%h want %h d0=%h want %h", n, rsp_valid1, rsp_valid0, exp_valid, rsp_data1, exp_d1, rsp_data0, exp_d0);
            end
        end
        idle();
    endtask

    task automatic test_clr();
        req_valid = 1'b1;
        req_index = 4'd1;
        req_way = 2'd1;
        req_wmask = 32'hFFFF_FFFF;
        req_wdata = a5;
        clr = 1'b1;
        #1;
        checks++;
        if (ready1 !== 1'b0 || ready0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got %b/%b want 0", ready1, ready0);
        end
        step();
        clr = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_rsp: got %b/%b want 0", rsp_valid1, rsp_valid0);
        end
        count_init("clr");
        read_all_zero("clr_read");
    endtask

    task automatic test_rst_drop();
        issue(2, 1, 32'hFFFF_FFFF, a5);
        issue(2, 1, 32'h0, rnd_line());
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop_now: got %b/%b want 0", rsp_valid1, rsp_valid0);
        end
        step();
        checks++;
        if (rsp_valid1 !== 1'b0 || rsp_data1 !== '0 || rsp_data0 !== '0 || ready1 !== 1'b0 || init_done1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: valid=%b d1=%h d0=%h ready=%b want all 0", rsp_valid1, rsp_data1, rsp_data0, ready1);
        end
        rst = 1'b0;
        count_init("rst_drop");
        issue(2, 1, 32'h0, rnd_line());
        checks++;
        if (rsp_valid1 !== 1'b1 || rsp_data1 !== '0 || rsp_data0 !== '0) begin
            errors++;
            $display("FAIL rst_cleared: valid=%b d1=%h d0=%h want 1 and zero", rsp_valid1, rsp_data1, rsp_data0);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_ways();
        test_back_to_back();
        test_clr();
        test_rst_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
